// File: rtl/jkc_pkg.sv
// jkc_pkg: shared types and constants for the JK counter sequencer.
//   op codes   : OP_CLR / OP_LD / OP_RUN / OP_STOP (cmd_op encoding)
//   state_t    : controller states ST_IDLE / ST_RUN / ST_DONE
//   jk_t       : J/K drive pair for one counter cell
package jkc_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_CLR  = 2'b00;
  localparam logic [OP_W-1:0] OP_LD   = 2'b01;
  localparam logic [OP_W-1:0] OP_RUN  = 2'b10;
  localparam logic [OP_W-1:0] OP_STOP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic j;
    logic k;
  } jk_t;

  localparam jk_t JK_HOLD   = '{j: 1'b0, k: 1'b0};
  localparam jk_t JK_RESET  = '{j: 1'b0, k: 1'b1};
  localparam jk_t JK_TOGGLE = '{j: 1'b1, k: 1'b1};

  // Drive that forces a cell to d on the next edge.
  function automatic jk_t jk_load(input logic d);
    jk_t r;
    r.j = d;
    r.k = ~d;
    return r;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// jk_cell: single JK flip-flop with async active-low clear.
//   clk, rst_n : clock, async active-low clear (q=0, qb=1)
//   j, k       : JK inputs (00 hold, 01 reset, 10 set, 11 toggle)
//   q, qb      : registered true / complement outputs
module jk_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  logic q_nxt;

  // JK characteristic function
  always_comb begin
    q_nxt = q;
    case ({j, k})
      2'b00:   q_nxt = q;
      2'b01:   q_nxt = 1'b0;
      2'b10:   q_nxt = 1'b1;
      default: q_nxt = ~q;
    endcase
  end

  // qb is kept as its own flop so both outputs are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q  <= 1'b0;
      qb <= 1'b1;
    end else begin
      q  <= q_nxt;
      qb <= ~q_nxt;
    end
  end

endmodule

// File: rtl/jk_counter_ctrl.sv
// jk_counter_ctrl: command-driven sequencer for a WIDTH-bit JK-cell counter.
//   clk, rst_n          : clock, async active-low reset
//   cmd_valid/cmd_ready : command handshake (ready low only in DONE)
//   cmd_op              : 00 CLEAR, 01 LOAD, 10 RUN, 11 STOP
//   cmd_data            : LOAD value or RUN target
//   cmd_dir             : RUN direction, 0 up / 1 down
//   tick                : step enable while running
//   count               : Q outputs of the JK cells
//   busy                : state == RUN
//   done, tc, err       : registered one-cycle pulses
// Build option: define JKC_DOWN_EN to enable down counting; otherwise
// cmd_dir is ignored and only up-step logic exists.
module jk_counter_ctrl
  import jkc_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc,
  output logic             err
);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   target, target_nxt;
  jk_t [WIDTH-1:0]    jk;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   qb_unused;
  logic [WIDTH-1:0]   up_t;
  logic [WIDTH-1:0]   step_t;
  logic [WIDTH-1:0]   q_step;
  logic               wrap;
  logic               accept;
  logic               done_nxt, tc_nxt, err_nxt;

  assign cmd_ready = (state != ST_DONE);
  assign busy      = (state == ST_RUN);
  assign accept    = cmd_valid & cmd_ready;
  assign count     = q;

  // Up toggle chain: cell i toggles when all lower bits are 1
  always_comb begin
    up_t    = '0;
    up_t[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      up_t[i] = up_t[i-1] & q[i-1];
    end
  end

`ifdef JKC_DOWN_EN
  logic             dir, dir_nxt;
  logic [WIDTH-1:0] dn_t;

  // Down toggle chain: cell i toggles when all lower bits are 0
  always_comb begin
    dn_t    = '0;
    dn_t[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      dn_t[i] = dn_t[i-1] & qb_unused[i-1];
    end
  end

  assign step_t = dir ? dn_t : up_t;
  assign wrap   = dir ? (q == '0) : (&q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir <= 1'b0;
    else        dir <= dir_nxt;
  end
`else
  logic dir_unused;
  assign dir_unused = cmd_dir;
  assign step_t     = up_t;
  assign wrap       = &q;
`endif

  // Value the cells will hold after a toggle step
  assign q_step = q ^ step_t;

  // Next-state, J/K drive and pulse generation
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
`ifdef JKC_DOWN_EN
    dir_nxt    = dir;
`endif
    done_nxt   = 1'b0;
    tc_nxt     = 1'b0;
    err_nxt    = 1'b0;
    jk         = {WIDTH{JK_HOLD}};

    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_CLR: jk = {WIDTH{JK_RESET}};
            OP_LD: begin
              for (int unsigned i = 0; i < WIDTH; i++) begin
                jk[i] = jk_load(cmd_data[i]);
              end
            end
            OP_RUN: begin
              target_nxt = cmd_data;
`ifdef JKC_DOWN_EN
              dir_nxt    = cmd_dir;
`endif
              // Already at target: finish without stepping
              state_nxt  = (cmd_data == q) ? ST_DONE : ST_RUN;
            end
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        if (accept && (cmd_op == OP_STOP)) begin
          // STOP beats a coincident tick: cells hold
          state_nxt = ST_IDLE;
        end else begin
          if (accept) err_nxt = 1'b1;
          if (tick) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
              jk[i] = step_t[i] ? JK_TOGGLE : JK_HOLD;
            end
            tc_nxt = wrap;
            if (q_step == target) state_nxt = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // Controller state and registered pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      target <= '0;
      done   <= 1'b0;
      tc     <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      target <= target_nxt;
      done   <= done_nxt;
      tc     <= tc_nxt;
      err    <= err_nxt;
    end
  end

  // Counter datapath: one JK cell per bit
  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (jk[g].j),
      .k     (jk[g].k),
      .q     (q[g]),
      .qb    (qb_unused[g])
    );
  end

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// tb_jk_counter_ctrl: scoreboard bench for jk_counter_ctrl (WIDTH=3).
// Down-count scenarios follow JKC_DOWN_EN if the build defines it.
module tb_jk_counter_ctrl;
  import jkc_pkg::*;

  localparam int unsigned WIDTH = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;
  logic             tick;
  logic [WIDTH-1:0] count;
  logic             busy, done, tc, err;

  jk_counter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_dir   (cmd_dir),
    .tick      (tick),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .tc        (tc),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic busy, ready, done, tc, err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   tc_seen, done_seen;

  // Reference model state: 0 idle, 1 run, 2 done
  int               m_state;
  logic [WIDTH-1:0] m_count, m_tgt;
  logic             m_dir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_count = '0;
    m_tgt   = '0;
    m_dir   = 1'b0;
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_count"}, 32'(count),     32'(e.count));
      chk({tag, "_busy"},  32'(busy),      32'(e.busy));
      chk({tag, "_ready"}, 32'(cmd_ready), 32'(e.ready));
      chk({tag, "_done"},  32'(done),      32'(e.done));
      chk({tag, "_tc"},    32'(tc),        32'(e.tc));
      chk({tag, "_err"},   32'(err),       32'(e.err));
      tc_seen   += int'(tc);
      done_seen += int'(done);
    end
  endtask

  // Drive one cycle of stimulus, predict post-edge outputs, compare after the edge
  task automatic drive(input string tag, input logic v, input logic [1:0] op,
                       input logic [WIDTH-1:0] data, input logic dir, input logic tk);
    exp_t e;
    logic acc;
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = data;
    cmd_dir   = dir;
    tick      = tk;
    acc   = v && (m_state != 2);
    e.done = 1'b0;
    e.tc   = 1'b0;
    e.err  = 1'b0;
    case (m_state)
      0: begin
        if (acc) begin
          if (op == OP_CLR) m_count = '0;
          else if (op == OP_LD) m_count = data;
          else if (op == OP_RUN) begin
            m_tgt = data;
`ifdef JKC_DOWN_EN
            m_dir = dir;
`else
            m_dir = 1'b0;
`endif
            m_state = (data == m_count) ? 2 : 1;
          end
        end
      end
      1: begin
        if (acc && op == OP_STOP) m_state = 0;
        else begin
          if (acc) e.err = 1'b1;
          if (tk) begin
            if (m_dir) begin
              if (m_count == 0) e.tc = 1'b1;
              m_count = m_count - 1'b1;
            end else begin
              if (m_count == 3'd7) e.tc = 1'b1;
              m_count = m_count + 1'b1;
            end
            if (m_count == m_tgt) m_state = 2;
          end
        end
      end
      default: begin
        e.done  = 1'b1;
        m_state = 0;
      end
    endcase
    e.count = m_count;
    e.busy  = (m_state == 1);
    e.ready = (m_state != 2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    sb_check(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive("idle", 1'b0, OP_CLR, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_CLR;
    cmd_data  = '0;
    cmd_dir   = 1'b0;
    tick      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_tc",    32'(tc),    32'd0);
    chk("rst_err",   32'(err),   32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LOAD / CLEAR
    drive("load5", 1'b1, OP_LD, 3'd5, 1'b0, 1'b0);
    chk("load5_val", 32'(count), 32'd5);
    drive("clear", 1'b1, OP_CLR, 3'd0, 1'b0, 1'b0);
    chk("clear_val", 32'(count), 32'd0);

    // Up run with wrap 6 -> 7,0,1
    drive("load6", 1'b1, OP_LD, 3'd6, 1'b0, 1'b0);
    tc_seen = 0; done_seen = 0;
    drive("run_up", 1'b1, OP_RUN, 3'd1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) drive("up_step", 1'b0, OP_CLR, '0, 1'b0, 1'b1);
    chk("up_tc_once",   32'(tc_seen),   32'd1);
    chk("up_done_once", 32'(done_seen), 32'd1);
    chk("up_final",     32'(count),     32'd1);

    // Down run with wrap 2 -> 1,0,7,6
    drive("load2", 1'b1, OP_LD, 3'd2, 1'b0, 1'b0);
    tc_seen = 0; done_seen = 0;
    drive("run_dn", 1'b1, OP_RUN, 3'd6, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) drive("dn_step", 1'b0, OP_CLR, '0, 1'b0, 1'b1);
    chk("dn_final",     32'(count),     32'd6);
    chk("dn_done_once", 32'(done_seen), 32'd1);

    // Tick gating
    drive("clr2", 1'b1, OP_CLR, 3'd0, 1'b0, 1'b0);
    drive("run_tk", 1'b1, OP_RUN, 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) drive("tk_step", 1'b0, OP_CLR, '0, 1'b0, (i % 2) == 0);
    chk("tk_final", 32'(count), 32'd4);

    // STOP with simultaneous tick, then commands in RUN
    drive("clr3", 1'b1, OP_CLR, 3'd0, 1'b0, 1'b0);
    drive("run_st", 1'b1, OP_RUN, 3'd5, 1'b0, 1'b0);
    drive("st_step", 1'b0, OP_CLR, '0, 1'b0, 1'b1);
    drive("st_step", 1'b0, OP_CLR, '0, 1'b0, 1'b1);
    drive("stop_tick", 1'b1, OP_STOP, '0, 1'b0, 1'b1);
    chk("stop_held", 32'(count), 32'd2);
    chk("stop_idle", 32'(busy),  32'd0);
    drive("run_err", 1'b1, OP_RUN, 3'd5, 1'b0, 1'b0);
    drive("ld_in_run", 1'b1, OP_LD, 3'd3, 1'b0, 1'b0);
    chk("ld_err", 32'(err), 32'd1);
    drive("clr_in_run", 1'b1, OP_CLR, 3'd0, 1'b0, 1'b1);
    drive("stop2", 1'b1, OP_STOP, '0, 1'b0, 1'b0);
    idle(1);

    // Reset in the middle of RUN
    drive("run_rst", 1'b1, OP_RUN, 3'd7, 1'b0, 1'b0);
    drive("rst_step", 1'b0, OP_CLR, '0, 1'b0, 1'b1);
    cmd_valid = 1'b0;
    tick      = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_busy",  32'(busy),  32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    // RUN with target equal to count: DONE without stepping; DONE refuses commands
    tc_seen = 0; done_seen = 0;
    drive("run_eq", 1'b1, OP_RUN, 3'd0, 1'b0, 1'b1);
    chk("eq_not_ready", 32'(cmd_ready), 32'd0);
    drive("ld_in_done", 1'b1, OP_LD, 3'd5, 1'b0, 1'b1);
    chk("eq_done", 32'(done), 32'd1);
    idle(2);
    chk("eq_done_once", 32'(done_seen), 32'd1);
    chk("eq_count", 32'(count), 32'd0);

    cmd_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
